// File: rtl/alu_issue_stage_pkg.sv
// Shared constants, types and decode helpers for the ALU issue stage.
package alu_issue_stage_pkg;

  localparam int XLEN = 32;

  // ALU operation encodings understood by the downstream ALU.
  typedef enum logic [3:0] {
    ALU_ADD              = 4'd0,
    ALU_SUB              = 4'd1,
    ALU_AND              = 4'd2,
    ALU_OR               = 4'd3,
    ALU_XOR              = 4'd4,
    ALU_SHIFTL           = 4'd5,
    ALU_SHIFTR           = 4'd6,
    ALU_SHIFTR_ARITH     = 4'd7,
    ALU_LESS_THAN        = 4'd8,
    ALU_LESS_THAN_SIGNED = 4'd9
  } alu_op_e;

  // RV32I major opcodes (instr[6:0]).
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {OP1_RS1, OP1_PC, OP1_ZERO} op1_sel_e;
  typedef enum logic [1:0] {OP2_RS2, OP2_IMM, OP2_FOUR} op2_sel_e;

  typedef struct packed {
    alu_op_e  alu_op;
    op1_sel_e op1_sel;
    op2_sel_e op2_sel;
    logic     reg_write;
    logic     illegal;
  } dec_t;

  // funct3/funct7[5] to ALU op for OP and OP-IMM; OP-IMM has no SUB.
  function automatic alu_op_e arith_op(input logic [2:0] f3, input logic f7_5,
                                       input logic is_imm);
    alu_op_e op;
    case (f3)
      3'd0:    op = (f7_5 && !is_imm) ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SHIFTL;
      3'd2:    op = ALU_LESS_THAN_SIGNED;
      3'd3:    op = ALU_LESS_THAN;
      3'd4:    op = ALU_XOR;
      3'd5:    op = f7_5 ? ALU_SHIFTR_ARITH : ALU_SHIFTR;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Full instruction decode into ALU op, operand sources and writeback flags.
  function automatic dec_t decode(input logic [6:0] opcode, input logic [2:0] f3,
                                  input logic f7_5);
    dec_t d;
    d = '{alu_op: ALU_ADD, op1_sel: OP1_RS1, op2_sel: OP2_RS2,
          reg_write: 1'b0, illegal: 1'b0};
    case (opcode)
      OPC_OP:     begin d.alu_op = arith_op(f3, f7_5, 1'b0); d.reg_write = 1'b1; end
      OPC_OP_IMM: begin
        d.alu_op = arith_op(f3, f7_5, 1'b1); d.op2_sel = OP2_IMM; d.reg_write = 1'b1;
      end
      OPC_LOAD:   begin d.op2_sel = OP2_IMM; d.reg_write = 1'b1; end
      OPC_STORE:  d.op2_sel = OP2_IMM;
      OPC_LUI:    begin d.op1_sel = OP1_ZERO; d.op2_sel = OP2_IMM; d.reg_write = 1'b1; end
      OPC_AUIPC:  begin d.op1_sel = OP1_PC; d.op2_sel = OP2_IMM; d.reg_write = 1'b1; end
      OPC_JAL, OPC_JALR: begin
        d.op1_sel = OP1_PC; d.op2_sel = OP2_FOUR; d.reg_write = 1'b1;
      end
      OPC_BRANCH: d.alu_op = ALU_SUB;
      default:    d.illegal = 1'b1;
    endcase
    return d;
  endfunction

  function automatic logic is_shift(input alu_op_e op);
    return (op == ALU_SHIFTL) || (op == ALU_SHIFTR) || (op == ALU_SHIFTR_ARITH);
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Decode-side, forwarding and ALU-side buses of the issue stage.
// Handshake: a transfer happens on a rising edge where valid && ready; the
// producer holds valid and its payload stable until that edge, and ready may
// depend combinationally on the consumer's own state and downstream ready.
interface alu_issue_stage_if import alu_issue_stage_pkg::*; ();
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_rs1_data;
  logic [XLEN-1:0] in_rs2_data;
  logic [XLEN-1:0] in_imm;
  logic [4:0]      in_rs1_addr;
  logic [4:0]      in_rs2_addr;
  logic [4:0]      in_rd_addr;
  logic [6:0]      in_opcode;
  logic [2:0]      in_funct3;
  logic            in_funct7_5;
  logic            flush;
  logic            exmem_reg_write;
  logic [4:0]      exmem_rd;
  logic [XLEN-1:0] exmem_result;
  logic            memwb_reg_write;
  logic [4:0]      memwb_rd;
  logic [XLEN-1:0] memwb_result;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_inp1;
  logic [XLEN-1:0] alu_inp2;
  logic [3:0]      alu_control;
  logic [4:0]      out_rd;
  logic            out_reg_write;
  logic            out_illegal;

  modport master (
    output in_valid, in_pc, in_rs1_data, in_rs2_data, in_imm, in_rs1_addr, in_rs2_addr,
           in_rd_addr, in_opcode, in_funct3, in_funct7_5, flush, exmem_reg_write, exmem_rd,
           exmem_result, memwb_reg_write, memwb_rd, memwb_result, out_ready,
    input  in_ready, out_valid, alu_inp1, alu_inp2, alu_control, out_rd, out_reg_write,
           out_illegal
  );

  modport slave (
    input  in_valid, in_pc, in_rs1_data, in_rs2_data, in_imm, in_rs1_addr, in_rs2_addr,
           in_rd_addr, in_opcode, in_funct3, in_funct7_5, flush, exmem_reg_write, exmem_rd,
           exmem_result, memwb_reg_write, memwb_rd, memwb_result, out_ready,
    output in_ready, out_valid, alu_inp1, alu_inp2, alu_control, out_rd, out_reg_write,
           out_illegal
  );
endinterface

// File: rtl/alu_issue_stage_fwd_select.sv
// Operand bypass: youngest producer (EX/MEM) wins over MEM/WB, x0 is never bypassed.
module alu_issue_stage_fwd_select import alu_issue_stage_pkg::*; (
  input  logic [4:0]      rs_addr_i,
  input  logic [XLEN-1:0] rs_data_i,
  input  logic            exmem_reg_write_i,
  input  logic [4:0]      exmem_rd_i,
  input  logic [XLEN-1:0] exmem_result_i,
  input  logic            memwb_reg_write_i,
  input  logic [4:0]      memwb_rd_i,
  input  logic [XLEN-1:0] memwb_result_i,
  output logic [XLEN-1:0] operand_o
);

  // Priority select between the two bypass buses and the held register value.
  always_comb begin
    operand_o = rs_data_i;
    if (rs_addr_i != 5'd0) begin
      if (exmem_reg_write_i && (exmem_rd_i == rs_addr_i)) begin
        operand_o = exmem_result_i;
      end else if (memwb_reg_write_i && (memwb_rd_i == rs_addr_i)) begin
        operand_o = memwb_result_i;
      end
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX stage: holds one decoded instruction and presents forwarded ALU operands.
module alu_issue_stage import alu_issue_stage_pkg::*; (
  input logic              clk,
  input logic              rst,
  alu_issue_stage_if.slave bus
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, rs1_data_q, rs2_data_q, imm_q;
  logic [4:0]      rs1_addr_q, rs2_addr_q, rd_q;
  dec_t            dec_q, dec_d;
  logic            in_ready, accept, load_en;
  logic [XLEN-1:0] rs1_fwd, rs2_fwd, op1, op2;

  assign in_ready = !valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;
  // A flush also kills an instruction arriving in the same cycle.
  assign load_en  = accept && !bus.flush;

  // Decode the incoming instruction so only the result is registered.
  always_comb dec_d = decode(bus.in_opcode, bus.in_funct3, bus.in_funct7_5);

  // Occupancy next state: flush > accept > drain on downstream ready > hold.
  always_comb begin
    valid_d = valid_q;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
    end else if (valid_q && bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Held instruction registers; fields only change on an accepted load.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rd_q       <= '0;
      dec_q      <= '{alu_op: ALU_ADD, op1_sel: OP1_RS1, op2_sel: OP2_RS2,
                      reg_write: 1'b0, illegal: 1'b0};
    end else begin
      valid_q <= valid_d;
      if (load_en) begin
        pc_q       <= bus.in_pc;
        rs1_data_q <= bus.in_rs1_data;
        rs2_data_q <= bus.in_rs2_data;
        imm_q      <= bus.in_imm;
        rs1_addr_q <= bus.in_rs1_addr;
        rs2_addr_q <= bus.in_rs2_addr;
        rd_q       <= bus.in_rd_addr;
        dec_q      <= dec_d;
      end
    end
  end

  alu_issue_stage_fwd_select u_fwd_rs1 (
    .rs_addr_i(rs1_addr_q), .rs_data_i(rs1_data_q),
    .exmem_reg_write_i(bus.exmem_reg_write), .exmem_rd_i(bus.exmem_rd),
    .exmem_result_i(bus.exmem_result), .memwb_reg_write_i(bus.memwb_reg_write),
    .memwb_rd_i(bus.memwb_rd), .memwb_result_i(bus.memwb_result), .operand_o(rs1_fwd)
  );

  alu_issue_stage_fwd_select u_fwd_rs2 (
    .rs_addr_i(rs2_addr_q), .rs_data_i(rs2_data_q),
    .exmem_reg_write_i(bus.exmem_reg_write), .exmem_rd_i(bus.exmem_rd),
    .exmem_result_i(bus.exmem_result), .memwb_reg_write_i(bus.memwb_reg_write),
    .memwb_rd_i(bus.memwb_rd), .memwb_result_i(bus.memwb_result), .operand_o(rs2_fwd)
  );

  // Operand muxes; forwarding stays live while the instruction is stalled.
  always_comb begin
    op1 = rs1_fwd;
    case (dec_q.op1_sel)
      OP1_PC:   op1 = pc_q;
      OP1_ZERO: op1 = '0;
      default:  op1 = rs1_fwd;
    endcase
    op2 = rs2_fwd;
    case (dec_q.op2_sel)
      OP2_IMM:  op2 = imm_q;
      OP2_FOUR: op2 = XLEN'(4);
      default:  op2 = rs2_fwd;
    endcase
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = valid_q;
  assign bus.alu_inp1      = op1;
  // Shift amount is only the low five bits of the second operand.
  assign bus.alu_inp2      = is_shift(dec_q.alu_op) ? {{(XLEN-5){1'b0}}, op2[4:0]} : op2;
  assign bus.alu_control   = dec_q.alu_op;
  assign bus.out_rd        = rd_q;
  assign bus.out_reg_write = dec_q.reg_write && (rd_q != 5'd0);
  assign bus.out_illegal   = dec_q.illegal;

endmodule
